sram_write_master: RTL and testbench
====================================

# sram_write_master

Wishbone write master that takes one word at a time from the FIFO-to-SRAM stage (`sram_start`/`sram_data`) and writes it into a circular buffer in SRAM. It arbitrates for the shared bus and answers the upstream stage with `grant` while the write is in flight. It then returns a one-cycle `data_done` pulse.

## Interface
Parameters:
- TIMEOUT, 255: cycles to wait for `wb_ack_i`/`wb_err_i` before abandoning the write.
- PTR_WIDTH, 16: width of the buffer word index.

Ports:
- wb_clk  in  1  clock.
- wb_rst  in  1  reset, asynchronous, active-low.
- enable  in  1  block enable; low aborts pending requests and clears state.
- base_addr  in  32  buffer start byte address; bits [1:0] are ignored.
- buf_words  in  PTR_WIDTH  buffer length in words; 0 is treated as 1.
- sram_start  in  1  upstream has a word ready; level, held until `data_done`.
- sram_data  in  32  word to write; valid while `sram_start` is high.
- grant  out  1  high while this block owns the word and writes it.
- data_done  out  1  one-cycle pulse when the word is finished (ok or error).
- bus_req  out  1  request to the bus arbiter.
- bus_gnt  in  1  arbiter grant.
- wb_adr_o  out  32  address = {base_addr[31:2],2'b00} + wr_ptr*4.
- wb_dat_o  out  32  latched write data.
- wb_sel_o  out  4  4'hF during a cycle, otherwise 0.
- wb_we_o, wb_cyc_o, wb_stb_o  out  1  Wishbone controls.
- wb_ack_i, wb_err_i  in  1  Wishbone responses.
- wr_ptr  out  PTR_WIDTH  index of the next word to write.
- wrap  out  1  one-cycle pulse when `wr_ptr` wraps to 0.
- err  out  1  sticky error flag; cleared by `enable`=0.

## Operation
- All outputs are registered. Under reset, every output is 0 and the state is IDLE.
- State machine: IDLE, REQ, WRITE, DONE, HOLD.
- IDLE
  - Condition: `enable`&`sram_start`.
  - Action: latch `sram_data` into the data register, then go to REQ.
  - If `enable`=0: `wr_ptr` is cleared to 0 and `err` is cleared.
- REQ
  - `bus_req`=1.
  - On `bus_gnt`: go to WRITE and assert `grant`, `wb_cyc_o`, `wb_stb_o`, `wb_we_o` and `wb_sel_o`=F.
  - On `enable`=0: return to IDLE with `bus_req`=0 and no `data_done`.
- WRITE
  - `bus_req` stays 1 and the timeout counter runs.
  - `wb_ack_i`: go to DONE. `wr_ptr` increments; if it equals `buf_words`-1 it wraps to 0 and `wrap` pulses.
  - `wb_err_i` (takes priority over a simultaneous ack): go to DONE, set `err`, `wr_ptr` unchanged.
  - Counter reaches TIMEOUT: go to DONE, set `err`, `wr_ptr` unchanged.
  - `enable` falling during WRITE has no effect; the write completes.
- DONE
  - `data_done`=1. `grant`, `bus_req`, cyc, stb, we and sel are all 0.
  - Next state is HOLD.
- HOLD
  - Single idle cycle so the upstream stage can drop `sram_start`; then go to IDLE.
- `wb_adr_o` is computed from `wr_ptr` at WRITE entry and is stable throughout WRITE. Address arithmetic wraps modulo 2^32.
- If `buf_words` changes while nonzero and `wr_ptr` ≥ the new `buf_words`, the next increment wraps to 0.

## Timing
Minimum word period is 5 cycles, with `bus_gnt` and `wb_ack_i` tied high. Edge k is where the change is registered:
- k0: `sram_start` sampled, data latched.
- k1: `bus_req` rises.
- k2: cyc/stb/grant rise.
- k3: ack sampled, controls drop, `data_done` rises.
- k4: `data_done` falls (HOLD).
- k5: IDLE; a new `sram_start` can be accepted.

Other timing rules:
- Ack latency: each wait cycle on `wb_ack_i` or `bus_gnt` adds one cycle.
- Stb width: `wb_stb_o` stays high until the response edge; it never pulses twice per word.
- Timeout: TIMEOUT wait cycles in WRITE with no response abort the write.
- Async reset during WRITE: cyc/stb drop immediately and no `data_done` is produced.

## Test plan
- **Basic write.** base=0x1000, buf_words=4, single-cycle ack, word 0xA5B6C7D8 → `wb_adr_o`=0x1000 and `wb_dat_o`=A5B6C7D8 during the cycle. `data_done` is high for exactly 10 ns. `wr_ptr`=1.
- **Wrap.** Five words with buf_words=4 → addresses 0x1000, 0x1004, 0x1008, 0x100C, 0x1000. `wrap` pulses once, after the 4th ack.
- **Arbiter and slave stalls.** `bus_gnt` delayed 3 cycles and ack delayed 2 cycles → `grant` is high only during WRITE. `data_done` occurs 3+2 cycles later than the 5-cycle baseline.
- **Error response.** `wb_err_i` on the 2nd word → `err`=1, `wr_ptr` stays 1, `data_done` pulses. `enable`=0 then clears `err` and `wr_ptr`.
- **Timeout.** No ack with TIMEOUT=8 → `data_done` 8 cycles after stb rises, `err`=1, cyc=0.
- **Reset mid-write.** `wb_rst` low during WRITE → all outputs 0 asynchronously. After release, state is IDLE with `wr_ptr`=0.

Source files
------------

// File: rtl/sram_write_master_if.sv
// sram_write_master_if
//   Arbiter handshake plus Wishbone master signals of the SRAM write path.
//   master : bus_req, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o out;
//            bus_gnt, wb_ack_i, wb_err_i in.
//   slave  : mirror of master (arbiter + SRAM controller side).
interface sram_write_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output bus_req, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  bus_gnt, wb_ack_i, wb_err_i
  );

  modport slave (
    input  bus_req, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output bus_gnt, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/sram_write_master.sv
// sram_write_master
//   Takes one word at a time from the upstream stage (sram_start/sram_data),
//   arbitrates for the shared bus and writes it into a circular SRAM buffer.
//   Ports:
//     wb_clk, wb_rst (async, active-low)  clock / reset
//     enable                  low aborts a pending request, clears wr_ptr/err
//     base_addr, buf_words    circular buffer placement and length (0 -> 1)
//     sram_start, sram_data   upstream word handshake (level until data_done)
//     grant                   high while the word is being written
//     data_done               one-cycle completion pulse (ok or error)
//     bus                     arbiter + Wishbone master signals
//     wr_ptr, wrap, err       next word index, wrap pulse, sticky error
//   All outputs are registered.
module sram_write_master #(
  parameter int TIMEOUT   = 255,
  parameter int PTR_WIDTH = 16
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 enable,
  input  logic [31:0]          base_addr,
  input  logic [PTR_WIDTH-1:0] buf_words,
  input  logic                 sram_start,
  input  logic [31:0]          sram_data,
  output logic                 grant,
  output logic                 data_done,
  sram_write_master_if.master  bus,
  output logic [PTR_WIDTH-1:0] wr_ptr,
  output logic                 wrap,
  output logic                 err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WRITE, DONE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [31:0]          dat_q, dat_d;
  logic [31:0]          adr_q, adr_d;
  logic                 bus_req_q, bus_req_d;
  logic                 cyc_q, cyc_d;
  logic                 grant_q, grant_d;
  logic                 done_q, done_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Byte-lane bits of the base are dropped; word index scaled to bytes.
  logic [31:0]          base_al;
  logic [31:0]          ptr_off;
  logic [PTR_WIDTH-1:0] last_idx;
  logic                 unused_base_lsb;

  assign base_al         = {base_addr[31:2], 2'b00};
  assign ptr_off         = 32'(ptr_q) << 2;
  assign unused_base_lsb = ^base_addr[1:0];
  // A zero-length buffer behaves as a single word.
  assign last_idx        = (buf_words == '0) ? '0 : buf_words - 1'b1;

  always_comb begin
    state_d   = state_q;
    dat_d     = dat_q;
    adr_d     = adr_q;
    bus_req_d = bus_req_q;
    cyc_d     = cyc_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    err_d     = err_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        bus_req_d = 1'b0;
        cyc_d     = 1'b0;
        grant_d   = 1'b0;
        if (!enable) begin
          ptr_d = '0;
          err_d = 1'b0;
        end else if (sram_start) begin
          dat_d   = sram_data;
          state_d = REQ;
        end
      end

      REQ: begin
        if (!enable) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          bus_req_d = 1'b1;
          // Grant is only honoured once our request is actually visible.
          if (bus_req_q && bus.bus_gnt) begin
            state_d = WRITE;
            cyc_d   = 1'b1;
            grant_d = 1'b1;
            adr_d   = base_al + ptr_off;
            cnt_d   = '0;
          end
        end
      end

      WRITE: begin
        // enable is ignored here: a started bus cycle always completes.
        if (bus.wb_err_i || bus.wb_ack_i || cnt_q == CNT_LAST) begin
          state_d   = DONE;
          cyc_d     = 1'b0;
          grant_d   = 1'b0;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          if (bus.wb_err_i || !bus.wb_ack_i) begin
            err_d = 1'b1;
          end else if (ptr_q >= last_idx) begin
            // >= also covers a buffer shrunk below the current pointer.
            ptr_d  = '0;
            wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: state_d = HOLD;

      // One quiet cycle so upstream can drop sram_start after data_done.
      HOLD: state_d = IDLE;

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
        cyc_d     = 1'b0;
        grant_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q   <= IDLE;
      dat_q     <= '0;
      adr_q     <= '0;
      bus_req_q <= 1'b0;
      cyc_q     <= 1'b0;
      grant_q   <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dat_q     <= dat_d;
      adr_q     <= adr_d;
      bus_req_q <= bus_req_d;
      cyc_q     <= cyc_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.bus_req  = bus_req_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_sel_o = {4{cyc_q}};
  assign bus.wb_we_o  = cyc_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign grant        = grant_q;
  assign data_done    = done_q;
  assign wr_ptr       = ptr_q;
  assign wrap         = wrap_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sram_write_master.sv
module tb_sram_write_master;
  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] base_addr = 32'h0000_1000;
  logic [15:0] buf_words = 16'd4;
  logic        sram_start = 1'b0;
  logic [31:0] sram_data = '0;
  logic        grant, data_done, wrap, err;
  logic [15:0] wr_ptr;

  int tests = 0;
  int fails = 0;

  sram_write_master_if bus ();

  sram_write_master #(.TIMEOUT(8), .PTR_WIDTH(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable),
    .base_addr(base_addr), .buf_words(buf_words),
    .sram_start(sram_start), .sram_data(sram_data),
    .grant(grant), .data_done(data_done), .bus(bus),
    .wr_ptr(wr_ptr), .wrap(wrap), .err(err)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    @(negedge wb_clk);
  endtask

  // Drives one word and plays arbiter + slave. lat counts rising edges from
  // the sram_start sampling edge up to the one that raises data_done.
  task automatic run_word(input logic [31:0] d, input int gnt_wait, input int ack_wait,
                          input bit give_err, input bit respond,
                          output int lat, output logic [31:0] adr, output logic [31:0] dat,
                          output logic [3:0] sel, output int wraps, output bit grant_ok);
    int  rq = 0;
    int  cy = 0;
    bit  seen = 0;
    lat = 0; wraps = 0; grant_ok = 1; adr = 'x; dat = 'x; sel = 'x;
    sram_data  = d;
    sram_start = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      lat++;
      if (wrap) wraps++;
      if (grant !== bus.wb_cyc_o || bus.wb_stb_o !== bus.wb_cyc_o) grant_ok = 0;
      if (data_done) begin
        seen = 1;
      end else begin
        if (bus.wb_cyc_o) begin
          adr = bus.wb_adr_o; dat = bus.wb_dat_o;
          sel = {bus.wb_sel_o[3:1], bus.wb_sel_o[0] & bus.wb_we_o};
        end
        bus.bus_gnt = bus.bus_req && (rq >= gnt_wait);
        if (bus.bus_req) rq++;
        bus.wb_ack_i = bus.wb_cyc_o && respond && !give_err && (cy >= ack_wait);
        bus.wb_err_i = bus.wb_cyc_o && respond &&  give_err && (cy >= ack_wait);
        if (bus.wb_cyc_o) cy++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    bus.bus_gnt = 1'b0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    sram_start = 1'b0;
    chk("ctl_low_at_done", {bus.wb_cyc_o, bus.wb_stb_o, grant, bus.bus_req}, 32'd0);
    tick();
    chk("done_width", 32'(data_done), 32'd0);
    tick();
  endtask

  int          lat, wraps, total_wraps;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  bit          gok;

  initial begin
    bus.bus_gnt = 1'b0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;

    // Reset state
    #12;
    chk("rst_outs", {grant, data_done, wrap, err, bus.bus_req, bus.wb_cyc_o,
                     bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o}, 32'd0);
    chk("rst_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'd0);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    enable = 1'b1;
    tick();

    // Basic write
    run_word(32'hA5B6_C7D8, 0, 0, 0, 1, lat, adr, dat, sel, wraps, gok);
    chk("basic_lat", 32'(lat), 32'd4);
    chk("basic_adr", adr, 32'h0000_1000);
    chk("basic_dat", dat, 32'hA5B6_C7D8);
    chk("basic_sel", 32'(sel), 32'hF);
    chk("basic_grant", 32'(gok), 32'd1);
    chk("basic_ptr", 32'(wr_ptr), 32'd1);

    // Wrap: words 2..5 of a 4-word buffer
    total_wraps = 0;
    run_word(32'h1111_0002, 0, 0, 0, 1, lat, adr, dat, sel, wraps, gok);
    total_wraps += wraps;
    chk("wrap_adr2", adr, 32'h0000_1004);
    run_word(32'h1111_0003, 0, 0, 0, 1, lat, adr, dat, sel, wraps, gok);
    total_wraps += wraps;
    chk("wrap_adr3", adr, 32'h0000_1008);
    run_word(32'h1111_0004, 0, 0, 0, 1, lat, adr, dat, sel, wraps, gok);
    chk("wrap_adr4", adr, 32'h0000_100C);
    chk("wrap_at4", 32'(wraps), 32'd1);
    chk("wrap_ptr0", 32'(wr_ptr), 32'd0);
    total_wraps += wraps;
    run_word(32'h1111_0005, 0, 0, 0, 1, lat, adr, dat, sel, wraps, gok);
    total_wraps += wraps;
    chk("wrap_adr5", adr, 32'h0000_1000);
    chk("wrap_dat5", dat, 32'h1111_0005);
    chk("wrap_total", 32'(total_wraps), 32'd1);

    // Arbiter and slave stalls: 3 + 2 extra cycles
    run_word(32'hDEAD_BEEF, 3, 2, 0, 1, lat, adr, dat, sel, wraps, gok);
    chk("stall_lat", 32'(lat), 32'd9);
    chk("stall_grant", 32'(gok), 32'd1);
    chk("stall_adr", adr, 32'h0000_1004);
    chk("stall_ptr", 32'(wr_ptr), 32'd2);

    // Error response on 2nd word
    enable = 1'b0;
    tick();
    chk("dis_ptr", 32'(wr_ptr), 32'd0);
    enable = 1'b1;
    run_word(32'h0000_0001, 0, 0, 0, 1, lat, adr, dat, sel, wraps, gok);
    chk("err_w1_ptr", 32'(wr_ptr), 32'd1);
    chk("err_w1_err", 32'(err), 32'd0);
    run_word(32'h0000_0002, 0, 0, 1, 1, lat, adr, dat, sel, wraps, gok);
    chk("err_lat", 32'(lat), 32'd4);
    chk("err_set", 32'(err), 32'd1);
    chk("err_ptr", 32'(wr_ptr), 32'd1);
    enable = 1'b0;
    tick();
    chk("err_clr", 32'(err), 32'd0);
    chk("err_ptr_clr", 32'(wr_ptr), 32'd0);
    enable = 1'b1;

    // Timeout: no response, data_done 8 cycles after stb rises
    run_word(32'h5555_AAAA, 0, 0, 0, 0, lat, adr, dat, sel, wraps, gok);
    chk("to_lat", 32'(lat), 32'd11);
    chk("to_err", 32'(err), 32'd1);
    chk("to_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("to_ptr", 32'(wr_ptr), 32'd0);

    // enable dropped while waiting for grant
    enable = 1'b0;
    tick();
    enable = 1'b1;
    sram_start = 1'b1;
    tick();
    tick();
    chk("abort_req_hi", 32'(bus.bus_req), 32'd1);
    enable = 1'b0;
    tick();
    chk("abort_idle", {bus.bus_req, bus.wb_cyc_o, data_done, grant}, 32'd0);
    sram_start = 1'b0;
    tick();
    chk("abort_no_done", 32'(data_done), 32'd0);
    enable = 1'b1;

    // Reset mid-write
    run_word(32'h7777_0001, 0, 0, 0, 1, lat, adr, dat, sel, wraps, gok);
    chk("pre_rst_ptr", 32'(wr_ptr), 32'd1);
    sram_data = 32'h7777_0002;
    sram_start = 1'b1;
    bus.bus_gnt = 1'b1;
    tick(); tick(); tick();
    chk("mid_cyc", 32'(bus.wb_cyc_o), 32'd1);
    #2 wb_rst = 1'b0;
    #1;
    chk("async_rst", {bus.wb_cyc_o, bus.wb_stb_o, grant, bus.bus_req, data_done}, 32'd0);
    chk("async_ptr", 32'(wr_ptr), 32'd0);
    @(negedge wb_clk);
    sram_start = 1'b0;
    bus.bus_gnt = 1'b0;
    wb_rst = 1'b1;
    tick(); tick();
    chk("post_rst", {bus.bus_req, bus.wb_cyc_o, data_done, err}, 32'd0);
    chk("post_rst_ptr", 32'(wr_ptr), 32'd0);

    // buf_words = 0 behaves as a 1-word buffer: every write wraps
    buf_words = 16'd0;
    run_word(32'h0BAD_F00D, 0, 0, 0, 1, lat, adr, dat, sel, wraps, gok);
    chk("bw0_adr", adr, 32'h0000_1000);
    chk("bw0_wrap", 32'(wraps), 32'd1);
    chk("bw0_ptr", 32'(wr_ptr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
